// File: rtl/dequant_pair.sv
// dequant_pair: two-lane streaming dequantizer, 64-entry Q table, signed 16-bit saturation
module dequant_pair (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic        clr_i,
    input  logic        tbl_we_i,
    input  logic [4:0]  tbl_addr_i,
    input  logic [31:0] tbl_data_i,
    input  logic        in_valid_i,
    output logic        in_ready_o,
    input  logic [31:0] in_data_i,
    output logic        out_valid_o,
    input  logic        out_ready_i,
    output logic [31:0] out_data_o,
    output logic        out_last_o
);
    logic [31:0] tbl [32];
    logic [4:0]  cnt;
    logic        s1_valid;
    logic        s1_last;
    logic [31:0] s1_data;
    logic [31:0] s1_q;
    logic        adv2;
    logic        accept;

    function automatic logic [15:0] sat(input logic [15:0] c, input logic [15:0] q);
        logic signed [32:0] p;
        p = $signed({{17{c[15]}}, c}) * $signed({17'd0, q});
        return p > 33'sd32767 ? 16'h7fff : p < -33'sd32768 ? 16'h8000 : p[15:0];
    endfunction

    assign adv2       = !out_valid_o || out_ready_i;
    assign in_ready_o = !s1_valid || adv2;
    assign accept     = in_valid_i && in_ready_o && !clr_i;

    // Quantization table; clr leaves it intact, S1 reads the pre-edge value on collision
    always_ff @(posedge clk_i or posedge rst_i)
        if (rst_i)
            for (int i = 0; i < 32; i++) tbl[i] <= 32'h0001_0001;
        else if (tbl_we_i)
            tbl[tbl_addr_i] <= tbl_data_i;

    // Position of the next accepted pair within its 8x8 block
    always_ff @(posedge clk_i or posedge rst_i)
        if (rst_i)
            cnt <= 5'd0;
        else if (clr_i)
            cnt <= 5'd0;
        else if (accept)
            cnt <= cnt + 5'd1;

    // Stage 1: capture coefficient pair with its table word and end-of-block flag
    always_ff @(posedge clk_i or posedge rst_i)
        if (rst_i) begin
            s1_valid <= 1'b0;
            s1_last  <= 1'b0;
            s1_data  <= 32'd0;
            s1_q     <= 32'd0;
        end else if (clr_i) begin
            s1_valid <= 1'b0;
        end else if (in_ready_o) begin
            s1_valid <= in_valid_i;
            if (in_valid_i) begin
                s1_data <= in_data_i;
                s1_q    <= tbl[cnt];
                s1_last <= cnt == 5'd31;
            end
        end

    // Stage 2: per-lane multiply and saturate into the output register
    always_ff @(posedge clk_i or posedge rst_i)
        if (rst_i) begin
            out_valid_o <= 1'b0;
            out_last_o  <= 1'b0;
            out_data_o  <= 32'd0;
        end else if (clr_i) begin
            out_valid_o <= 1'b0;
            out_last_o  <= 1'b0;
        end else if (adv2) begin
            out_valid_o <= s1_valid;
            out_last_o  <= s1_valid && s1_last;
            if (s1_valid)
                out_data_o <= {sat(s1_data[31:16], s1_q[31:16]), sat(s1_data[15:0], s1_q[15:0])};
        end
endmodule

// File: tb/tb_dequant_pair.sv
// tb_dequant_pair: randomized scoreboard bench for dequant_pair against an arithmetic model
module tb_dequant_pair;
    logic        clk = 1'b0;
    logic        rst;
    logic        clr;
    logic        tbl_we;
    logic [4:0]  tbl_addr;
    logic [31:0] tbl_data;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] in_data;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_data;
    logic        out_last;

    typedef struct {
        logic [31:0] d;
        logic        l;
    } exp_t;

    int          checks = 0;
    int          errors = 0;
    int          mq [64];
    int          mcnt;
    exp_t        exp_q [$];
    logic [31:0] stim [$];

    dequant_pair dut (
        .clk_i(clk), .rst_i(rst), .clr_i(clr),
        .tbl_we_i(tbl_we), .tbl_addr_i(tbl_addr), .tbl_data_i(tbl_data),
        .in_valid_i(in_valid), .in_ready_o(in_ready), .in_data_i(in_data),
        .out_valid_o(out_valid), .out_ready_i(out_ready),
        .out_data_o(out_data), .out_last_o(out_last)
    );

    always #5 clk = ~clk;

    // True product of a signed coefficient and unsigned Q, clamped to int16
    function automatic logic [15:0] ref_lane(input logic [15:0] c, input int q);
        longint p;
        p = longint'($signed(c)) * longint'(q);
        if (p > 32767) p = 32767;
        if (p < -32768) p = -32768;
        return p[15:0];
    endfunction

    task automatic push_model(input logic [31:0] d);
        exp_t e;
        e.d = {ref_lane(d[31:16], mq[2*mcnt]), ref_lane(d[15:0], mq[2*mcnt+1])};
        e.l = mcnt == 31;
        exp_q.push_back(e);
        mcnt = (mcnt + 1) % 32;
    endtask

    task automatic write_entry(input int a, input logic [31:0] d);
        tbl_we = 1'b1;
        tbl_addr = 5'(a);
        tbl_data = d;
        @(posedge clk);
        #1;
        tbl_we = 1'b0;
        mq[2*a] = int'(d[31:16]);
        mq[2*a+1] = int'(d[15:0]);
    endtask

    task automatic run_stream(input int valid_pct, input int ready_pct, input string name);
        int          idx = 0;
        int          cyc = 0;
        bit          prev_stall = 0;
        bit          acc;
        logic [31:0] prev_d = 0;
        logic        prev_l = 0;
        exp_t        e;
        while ((idx < stim.size() || exp_q.size() != 0) && cyc < 3000) begin
            in_valid = idx < stim.size() && $urandom_range(99) < valid_pct;
            in_data = idx < stim.size() ? stim[idx] : $urandom;
            out_ready = $urandom_range(99) < ready_pct;
            @(negedge clk);
            checks++;
            if (in_ready !== !(exp_q.size() == 2 && !out_ready)) begin
                errors++;
                $display("FAIL %s in_ready got %b expected %b (in flight %0d)", name, in_ready, !(exp_q.size() == 2 && !out_ready), exp_q.size());
            end
            if (prev_stall) begin
                checks++;
                if (out_valid !== 1'b1 || out_data !== prev_d || out_last !== prev_l) begin
                    errors++;
                    $display("FAIL %s stall_hold got v=%b d=%h l=%b expected v=1 d=%h l=%b", name, out_valid, out_data, out_last, prev_d, prev_l);
                end
            end
            if (out_valid && out_ready) begin
                checks++;
                if (exp_q.size() == 0) begin
                    errors++;
                    $display("FAIL %s spurious output got d=%h expected none", name, out_data);
                end else begin
                    e = exp_q.pop_front();
                    if (out_data !== e.d || out_last !== e.l) begin
                        errors++;
                        $display("FAIL %s data got d=%h l=%b expected d=%h l=%b", name, out_data, out_last, e.d, e.l);
                    end
                end
            end
            prev_stall = out_valid && !out_ready;
            prev_d = out_data;
            prev_l = out_last;
            acc = in_valid && in_ready;
            @(posedge clk);
            if (acc) begin
                push_model(in_data);
                idx++;
            end
            #1;
            cyc++;
        end
        in_valid = 1'b0;
        checks++;
        if (idx != stim.size() || exp_q.size() != 0) begin
            errors++;
            $display("FAIL %s timeout got sent=%0d pending=%0d expected sent=%0d pending=0", name, idx, exp_q.size(), stim.size());
        end
        stim.delete();
    endtask

    task automatic test_reset;
        rst = 1'b1;
        #12;
        checks++;
        if (in_ready !== 1'b1 || out_valid !== 1'b0 || out_data !== 32'd0 || out_last !== 1'b0) begin
            errors++;
            $display("FAIL reset got rdy=%b v=%b d=%h l=%b expected rdy=1 v=0 d=0 l=0", in_ready, out_valid, out_data, out_last);
        end
        @(posedge clk);
        #1;
        rst = 1'b0;
        for (int i = 0; i < 64; i++) mq[i] = 1;
        mcnt = 0;
        exp_q.delete();
    endtask

    task automatic test_passthrough;
        for (int k = 0; k < 32; k++) stim.push_back({16'(k), 16'(-k)});
        run_stream(100, 100, "passthrough");
    endtask

    task automatic test_latency;
        exp_t e;
        in_valid = 1'b1;
        in_data = 32'h1234_8765;
        out_ready = 1'b1;
        @(posedge clk);
        push_model(in_data);
        #1;
        in_valid = 1'b0;
        checks++;
        if (out_valid !== 1'b0) begin
            errors++;
            $display("FAIL latency_early got v=%b expected v=0", out_valid);
        end
        @(posedge clk);
        #1;
        e = exp_q.pop_front();
        checks++;
        if (out_valid !== 1'b1 || out_data !== e.d) begin
            errors++;
            $display("FAIL latency got v=%b d=%h expected v=1 d=%h", out_valid, out_data, e.d);
        end
        @(posedge clk);
        #1;
    endtask

    task automatic test_multiply;
        for (int a = 0; a < 32; a++) write_entry(a, 32'h0002_0003);
        stim.push_back(32'h0100_fffe);
        for (int i = 0; i < 20; i++) stim.push_back($urandom);
        run_stream(100, 100, "multiply");
    endtask

    task automatic test_saturation;
        for (int a = 0; a < 32; a++) write_entry(a, 32'h00ff_00ff);
        stim.push_back(32'h7fff_8000);
        stim.push_back(32'h0080_ff7f);
        for (int i = 0; i < 20; i++) stim.push_back($urandom);
        run_stream(90, 100, "saturation");
    endtask

    task automatic test_backpressure;
        for (int a = 0; a < 32; a++) write_entry(a, {16'($urandom_range(300)), 16'($urandom)});
        for (int i = 0; i < 96; i++) stim.push_back($urandom);
        run_stream(85, 50, "backpressure");
    endtask

    task automatic test_clear;
        clr = 1'b1;
        @(posedge clk);
        #1;
        clr = 1'b0;
        mcnt = 0;
        exp_q.delete();
        for (int i = 0; i < 8; i++) stim.push_back($urandom);
        run_stream(100, 100, "clear_pre");
        out_ready = 1'b0;
        in_valid = 1'b1;
        for (int i = 0; i < 2; i++) begin
            in_data = $urandom;
            @(posedge clk);
            push_model(in_data);
            #1;
        end
        @(negedge clk);
        checks++;
        if (in_ready !== 1'b0) begin
            errors++;
            $display("FAIL clear_full in_ready got %b expected 0", in_ready);
        end
        clr = 1'b1;
        out_ready = 1'b1;
        in_data = $urandom;
        @(negedge clk);
        checks++;
        if (in_ready !== 1'b1) begin
            errors++;
            $display("FAIL clear_ready got %b expected 1", in_ready);
        end
        @(posedge clk);
        #1;
        clr = 1'b0;
        in_valid = 1'b0;
        exp_q.delete();
        mcnt = 0;
        checks++;
        if (out_valid !== 1'b0 || out_last !== 1'b0) begin
            errors++;
            $display("FAIL clear_out got v=%b l=%b expected v=0 l=0", out_valid, out_last);
        end
        @(posedge clk);
        #1;
        checks++;
        if (out_valid !== 1'b0) begin
            errors++;
            $display("FAIL clear_s1 got v=%b expected v=0", out_valid);
        end
        for (int i = 0; i < 32; i++) stim.push_back($urandom);
        run_stream(100, 60, "clear_post");
    endtask

    task automatic test_collision;
        exp_t e;
        write_entry(0, 32'h0005_0007);
        in_valid = 1'b1;
        in_data = 32'h0010_fff0;
        out_ready = 1'b1;
        tbl_we = 1'b1;
        tbl_addr = 5'd0;
        tbl_data = 32'h0004_0004;
        @(posedge clk);
        push_model(in_data);
        mq[0] = 4;
        mq[1] = 4;
        #1;
        tbl_we = 1'b0;
        in_valid = 1'b0;
        @(posedge clk);
        #1;
        e = exp_q.pop_front();
        checks++;
        if (out_valid !== 1'b1 || out_data !== e.d || out_data !== 32'h0050_ff90) begin
            errors++;
            $display("FAIL collision_old got v=%b d=%h expected v=1 d=%h", out_valid, out_data, e.d);
        end
        @(posedge clk);
        #1;
        for (int i = 0; i < 32; i++) stim.push_back($urandom);
        run_stream(100, 100, "collision_next");
    endtask

    initial begin
        rst = 1'b0;
        clr = 1'b0;
        tbl_we = 1'b0;
        tbl_addr = 5'd0;
        tbl_data = 32'd0;
        in_valid = 1'b0;
        in_data = 32'd0;
        out_ready = 1'b1;
        test_reset;
        test_passthrough;
        test_latency;
        test_multiply;
        test_saturation;
        test_backpressure;
        test_clear;
        test_collision;
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
